sram_latch_arbiter: RTL and testbench
=====================================

# sram_latch_arbiter

Round-robin arbiter and access sequencer that shares one latch-based, asynchronous-read SRAM macro (AWIDTH address bits, DWIDTH data bits, active-low chip select, read/write-not strobe) among NREQ synchronous requesters. It accepts one request at a time and drives the macro's cs_n/r_wn/addr/wdata pins from registers with a setup/strobe/hold write sequence, so the transparent write latch never sees a glitch. It registers read data back to the granted requester. It sits between the SRAM macro and the client blocks that previously drove it directly.

## Interface
- AWIDTH, 8, SRAM address width; depth is 1<<AWIDTH
- DWIDTH, 8, SRAM data width
- NREQ, 4, number of requesters, legal 2..8
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; held high with fields stable until gnt
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AWIDTH  flattened addresses, requester i at [i*AWIDTH +: AWIDTH]
- req_wdata  in  NREQ*DWIDTH  flattened write data, same packing
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse
- done  out  NREQ  one-hot, one-cycle completion pulse
- rd_data  out  DWIDTH  registered read data, valid with done of a read
- busy  out  1  high whenever state != IDLE
- mem_cs_n  out  1  SRAM chip select, active low
- mem_r_wn  out  1  SRAM read/write-not
- mem_addr  out  AWIDTH  SRAM address
- mem_wdata  out  DWIDTH  SRAM write data
- mem_rdata  in  DWIDTH  SRAM asynchronous read data

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RDONE.
- IDLE: if any req bit is high, select the winner, register its we/addr/wdata, load mem_addr/mem_wdata, and go to SETUP. Otherwise stay.
- SETUP: gnt[winner]=1.
  - Write: cs_n=1, r_wn=1, go to STROBE.
  - Read: cs_n=0, r_wn=1. At the clock edge ending SETUP, capture mem_rdata into rd_data and go to RDONE.
- STROBE (write only): cs_n=0, r_wn=0, so the SRAM latch is open. Go to HOLD.
- HOLD (write only): cs_n=1, r_wn=1, addr/wdata unchanged, done[winner]=1. Go to IDLE.
- RDONE (read only): cs_n=1, done[winner]=1, rd_data valid. Go to IDLE.
- All mem_* outputs are driven directly from flops.
- mem_addr and mem_wdata change only on the IDLE->SETUP edge and are held through idle periods.
- mem_cs_n=0 together with mem_r_wn=0 occurs only in STROBE.
- rd_data holds its value until the next read capture.
- Arbitration is round-robin. The search starts at last_grant+1 modulo NREQ. last_grant updates on each acceptance and resets to NREQ-1, so requester 0 wins first after reset.
- Requests are sampled only in IDLE. A req still high after done starts a new transaction.
- A requester must drop req, or present its next request, no later than the cycle after gnt.

## Timing
- Reset values, asserted asynchronously: mem_cs_n=1, mem_r_wn=1, mem_addr=0, mem_wdata=0, gnt=0, done=0, rd_data=0, busy=0, state=IDLE, last_grant=NREQ-1.
- Cycle numbering: cycle 0 is the IDLE cycle in which req is sampled.
- Read: gnt in cycle 1, done and rd_data in cycle 2. Earliest next acceptance edge is at the end of cycle 3, giving 3 cycles per read.
- Write: gnt in cycle 1, SRAM latch open in cycle 2, done in cycle 3. That gives 4 cycles per write. Written data is readable by a read accepted in the following IDLE.
- Reset mid-operation: mem_cs_n goes high and mem_r_wn goes high immediately, closing any open latch window. The transaction is dropped with no done. A write interrupted in STROBE may have partially updated the addressed word.
- Simultaneous requests: exactly one gnt per transaction. The others wait, and req must stay high.

## Configuration
- Macro: SRAM_LATCH_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. last_grant is unused and the round-robin logic is removed.
- Undefined (default): round-robin as described above.
- State sequence and timing are identical in both builds.

## Test plan
- Write then read: requester 0 writes 0xA5 to addr 0x12, then reads addr 0x12. Required: gnt[0] in cycle 1, cs_n/r_wn both low only in cycle 2, done[0] in cycle 3. Read returns rd_data=0xA5 with done[0].
- All four requesters raise req with reads together after reset. Required: round-robin build grants in order 0,1,2,3, one gnt every 3 cycles; fixed-prio build with 0 and 3 held requesting grants 0 repeatedly and never 3.
- Hold check: write 0x3C to addr 0xFF. Required: mem_addr=0xFF and mem_wdata=0x3C stable from cycle 1 through HOLD and after; cs_n never low while addr/wdata change.
- Wrap-around: last_grant=3, only requester 0 requesting. Required: gnt[0] next. Addr 0x00 and 0xFF writes/reads are independent.
- Reset mid-write: assert rst_n low during STROBE. Required: mem_cs_n=1 asynchronously, no done, busy=0, and the first grant after release goes to requester 0.
- Idle: req=0 for 20 cycles. Required: gnt=0, done=0, busy=0, cs_n=1, mem_addr unchanged.

Source files
------------

// File: rtl/sram_latch_arbiter.sv
// Round-robin arbiter and setup/strobe/hold access sequencer for one latch-based async-read SRAM.
// Latency: gnt one cycle after the sampling IDLE cycle; read done +1 (3 cycles/read), write done +2 (4 cycles/write).
// Backpressure: one transaction at a time; losing requesters hold req until their gnt, requests sampled only in IDLE.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), asynchronous active-low reset
//   req_i/req_we_i            per-requester request and write-enable
//   req_addr_i/req_wdata_i    flattened per-requester address / write data (requester i at [i*W +: W])
//   gnt_o/done_o              one-hot acceptance / completion pulses
//   rd_data_o                 registered read data, valid with done of a read, held until next read
//   busy_o                    high while a transaction is in flight
//   mem_cs_n_o/mem_r_wn_o     SRAM chip select (active low) and read/write-not, both registered
//   mem_addr_o/mem_wdata_o    SRAM address and write data, registered, changed only on acceptance
//   mem_rdata_i               SRAM asynchronous read data
//
// Build option: define SRAM_LATCH_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins);
// default build is round-robin starting after the last granted requester.

module sram_latch_arbiter #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 8,
   parameter int NREQ   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ-1:0]          req_we_i,
   input  logic [NREQ*AWIDTH-1:0]   req_addr_i,
   input  logic [NREQ*DWIDTH-1:0]   req_wdata_i,
   output logic [NREQ-1:0]          gnt_o,
   output logic [NREQ-1:0]          done_o,
   output logic [DWIDTH-1:0]        rd_data_o,
   output logic                     busy_o,
   output logic                     mem_cs_n_o,
   output logic                     mem_r_wn_o,
   output logic [AWIDTH-1:0]        mem_addr_o,
   output logic [DWIDTH-1:0]        mem_wdata_o,
   input  logic [DWIDTH-1:0]        mem_rdata_i
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_RDONE  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       win_q, win_d;
   logic                we_q, we_d;
   logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                cs_n_q, cs_n_d;
   logic                r_wn_q, r_wn_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [NREQ-1:0]     done_q, done_d;
   logic [DWIDTH-1:0]   rd_data_q, rd_data_d;

   logic [IW-1:0]       sel;
   logic [AWIDTH-1:0]   addr_a  [NREQ];
   logic [DWIDTH-1:0]   wdata_a [NREQ];

   // Unflatten the request buses so the winner can be picked with a plain index.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         addr_a[k]  = req_addr_i[k*AWIDTH +: AWIDTH];
         wdata_a[k] = req_wdata_i[k*DWIDTH +: DWIDTH];
      end
   end

`ifdef SRAM_LATCH_ARBITER_FIXED_PRIO_EN
   // Descending scan so the lowest requesting index is the last assignment and wins.
   always_comb begin
      sel = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req_i[IW'(k)]) sel = IW'(k);
      end
   end
`else
   logic [IW-1:0]       last_q, last_d;
   logic                found;
   logic [IW-1:0]       cand;

   // Scan starting one past the previous winner, wrapping modulo NREQ.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(last_q) + 1 + k) % NREQ);
         if (!found && req_i[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (state_q == S_IDLE && (|req_i)) last_d = sel;
   end

   // Reset to NREQ-1 so requester 0 is first in line after reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) last_q <= IW'(NREQ-1);
      else          last_q <= last_d;
   end
`endif

   // Next-state and next-pin values. Every mem_* pin is computed one state ahead
   // and registered, so the SRAM only ever sees clean flop outputs.
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cs_n_d      = 1'b1;
      r_wn_d      = 1'b1;
      gnt_d       = '0;
      done_d      = '0;
      rd_data_d   = rd_data_q;

      case (state_q)
         S_IDLE: begin
            if (|req_i) begin
               state_d     = S_SETUP;
               win_d       = sel;
               we_d        = req_we_i[sel];
               mem_addr_d  = addr_a[sel];
               mem_wdata_d = wdata_a[sel];
               gnt_d[sel]  = 1'b1;
               // Reads select the macro during SETUP; writes keep it deselected
               // while address and data settle ahead of the strobe.
               cs_n_d      = req_we_i[sel];
            end
         end
         S_SETUP: begin
            if (we_q) begin
               state_d = S_STROBE;
               cs_n_d  = 1'b0;
               r_wn_d  = 1'b0;
            end else begin
               state_d        = S_RDONE;
               rd_data_d      = mem_rdata_i;
               done_d[win_q]  = 1'b1;
            end
         end
         S_STROBE: begin
            state_d       = S_HOLD;
            done_d[win_q] = 1'b1;
         end
         S_HOLD:  state_d = S_IDLE;
         S_RDONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         win_q       <= '0;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cs_n_q      <= 1'b1;
         r_wn_q      <= 1'b1;
         gnt_q       <= '0;
         done_q      <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cs_n_q      <= cs_n_d;
         r_wn_q      <= r_wn_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign rd_data_o   = rd_data_q;
   assign busy_o      = (state_q != S_IDLE);
   assign mem_cs_n_o  = cs_n_q;
   assign mem_r_wn_o  = r_wn_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_sram_latch_arbiter.sv
// Testbench for sram_latch_arbiter: SRAM latch model, directed timing checks and random rounds
// scored against a queue-based reference model (grant order and data per transaction).
module tb_sram_latch_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int NR = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [NR-1:0]   req, req_we;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]   gnt, done;
   logic [DW-1:0]   rd_data, mem_wdata, mem_rdata;
   logic            busy, cs_n, r_wn;
   logic [AW-1:0]   mem_addr;

   sram_latch_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NREQ(NR)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .gnt_o(gnt), .done_o(done), .rd_data_o(rd_data), .busy_o(busy),
      .mem_cs_n_o(cs_n), .mem_r_wn_o(r_wn), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   // Latch-based SRAM: transparent write while cs_n and r_wn are both low, async read.
   logic [DW-1:0] sram [1<<AW];
   always @(cs_n or r_wn or mem_addr or mem_wdata)
      if (!cs_n && !r_wn) sram[mem_addr] = mem_wdata;
   assign mem_rdata = sram[mem_addr];

   // Reference model state.
   logic [DW-1:0] ref_mem [1<<AW];
   bit            ref_vld [1<<AW];
   int            last_g;
   logic [DW-1:0] last_rd;

   typedef struct {int idx; bit we; logic [DW-1:0] data;} exp_t;
   int   exp_gnt[$];
   exp_t exp_done[$];

   bit            r_we   [NR];
   logic [AW-1:0] r_addr [NR];
   logic [DW-1:0] r_dat  [NR];

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one clock; requesters drop req in the cycle they see their grant.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      req = req & ~gnt;
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT pulses gnt or done.
   initial begin
      exp_t e;
      int   g;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (gnt != '0) begin
               chk("gnt_onehot", 64'($onehot(gnt)), 64'd1);
               if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
               else begin
                  g = exp_gnt.pop_front();
                  chk("gnt_idx", 64'(gnt), 64'(1 << g));
               end
            end
            if (done != '0) begin
               if (exp_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
               else begin
                  e = exp_done.pop_front();
                  chk("done_idx", 64'(done), 64'(1 << e.idx));
                  if (e.we) chk("rd_data_hold", 64'(rd_data), 64'(e.data));
                  else      chk("rd_data", 64'(rd_data), 64'(e.data));
               end
            end
         end
      end
   end

   // Predict grant order for a set of simultaneous requests, push expectations, then drive.
   task automatic plan_and_drive(input logic [NR-1:0] mask);
      int   order[$];
      int   k;
      exp_t e;
      for (int s = 1; s <= NR; s++) begin
`ifdef SRAM_LATCH_ARBITER_FIXED_PRIO_EN
         k = s - 1;
`else
         k = (last_g + s) % NR;
`endif
         if (mask[k]) order.push_back(k);
      end
      foreach (order[j]) begin
         k = order[j];
         exp_gnt.push_back(k);
         e.idx = k;
         e.we  = r_we[k];
         if (r_we[k]) begin
            ref_mem[r_addr[k]] = r_dat[k];
            ref_vld[r_addr[k]] = 1'b1;
            e.data = last_rd;
         end else begin
            last_rd = ref_mem[r_addr[k]];
            e.data  = last_rd;
         end
         exp_done.push_back(e);
         last_g = k;
      end
      for (int i = 0; i < NR; i++) begin
         if (mask[i]) begin
            req_we[i]             = r_we[i];
            req_addr[i*AW +: AW]  = r_addr[i];
            req_wdata[i*DW +: DW] = r_dat[i];
         end
      end
      req = req | mask;
   endtask

   task automatic wait_round(input bit chk_spacing);
      int gc[$];
      bit ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         tick();
         if (gnt != '0) gc.push_back(cyc);
         if (req == '0 && exp_done.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("round_complete", 64'(ok), 64'd1);
      if (!ok) begin
         req = '0;
         exp_gnt.delete();
         exp_done.delete();
      end
      if (chk_spacing)
         for (int j = 1; j < gc.size(); j++) chk("gnt_spacing", 64'(gc[j] - gc[j-1]), 64'd3);
   endtask

   task automatic set_one(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      r_we[i] = we; r_addr[i] = a; r_dat[i] = d;
   endtask

   initial begin
      logic [AW-1:0] a0;
      logic [NR-1:0] m;
      rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < (1<<AW); i++) begin ref_mem[i] = '0; ref_vld[i] = 1'b0; end
      last_g = NR - 1; last_rd = '0;
      repeat (3) tick();
      chk("rst_cs_n", 64'(cs_n), 64'd1);
      chk("rst_r_wn", 64'(r_wn), 64'd1);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_gnt_done", 64'({gnt, done}), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      // Write 0xA5 to 0x12 from requester 0, with cycle-by-cycle pin checks.
      set_one(0, 1'b1, 8'h12, 8'hA5);
      plan_and_drive(4'b0001);
      tick();  // cycle 1
      chk("wr_c1_cs_n", 64'({cs_n, r_wn}), 64'b11);
      chk("wr_c1_addr", 64'({mem_addr, mem_wdata}), 64'h12A5);
      tick();  // cycle 2
      chk("wr_c2_strobe", 64'({cs_n, r_wn}), 64'b00);
      tick();  // cycle 3
      chk("wr_c3_hold", 64'({cs_n, r_wn}), 64'b11);
      chk("wr_c3_busy", 64'(busy), 64'd1);
      wait_round(1'b0);

      // Read it back.
      set_one(0, 1'b0, 8'h12, 8'h00);
      plan_and_drive(4'b0001);
      tick();
      chk("rd_c1_cs", 64'({cs_n, r_wn}), 64'b01);
      tick();
      chk("rd_c2_cs", 64'({cs_n, busy}), 64'b11);
      wait_round(1'b0);
      chk("rd_value_A5", 64'(rd_data), 64'hA5);

      // Hold check: write 0x3C to 0xFF.
      set_one(1, 1'b1, 8'hFF, 8'h3C);
      plan_and_drive(4'b0010);
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk("hold_addr_wdata", 64'({mem_addr, mem_wdata}), 64'hFF3C);
         if (c == 2) chk("hold_strobe", 64'({cs_n, r_wn}), 64'b00);
         else        chk("hold_no_strobe", 64'(cs_n), 64'd1);
      end
      wait_round(1'b0);

      // Address 0x00 and 0xFF are independent words.
      set_one(1, 1'b1, 8'h00, 8'h11);
      set_one(2, 1'b1, 8'hFF, 8'h22);
      plan_and_drive(4'b0110);
      wait_round(1'b0);
      set_one(0, 1'b0, 8'h00, 8'h00);
      set_one(3, 1'b0, 8'hFF, 8'h00);
      plan_and_drive(4'b1001);
      wait_round(1'b0);

      // Reset during STROBE of a write from requester 2.
      exp_gnt.push_back(2);
      req_we[2] = 1'b1; req_addr[2*AW +: AW] = 8'h77; req_wdata[2*DW +: DW] = 8'h5A;
      req[2] = 1'b1;
      tick();
      tick();
      chk("mid_pre_strobe", 64'({cs_n, r_wn}), 64'b00);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_pins", 64'({cs_n, r_wn}), 64'b11);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      // The latch was open for the start of STROBE, so the word took the new data.
      ref_mem[8'h77] = 8'h5A; ref_vld[8'h77] = 1'b1;
      last_g = NR - 1; last_rd = '0;
      tick();
      chk("mid_no_done", 64'(done), 64'd0);
      tick();
      chk("mid_no_done2", 64'(done), 64'd0);
      rst_n = 1'b1;

      // All four read together after reset: grants 0,1,2,3, one every 3 cycles.
      set_one(0, 1'b0, 8'h12, 8'h00);
      set_one(1, 1'b0, 8'hFF, 8'h00);
      set_one(2, 1'b0, 8'h00, 8'h00);
      set_one(3, 1'b0, 8'h77, 8'h00);
      plan_and_drive(4'b1111);
      wait_round(1'b1);
      // Wrap-around: last grant was 3, requester 0 alone.
      plan_and_drive(4'b0001);
      wait_round(1'b0);

      // Idle for 20 cycles.
      a0 = mem_addr;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_quiet", 64'({gnt, done, busy, cs_n}), 64'd1);
         chk("idle_addr", 64'(mem_addr), 64'(a0));
      end

      // Random rounds.
      for (int r = 0; r < 40; r++) begin
         m = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            r_we[i] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
               0:       r_addr[i] = 8'h00;
               1:       r_addr[i] = 8'hFF;
               2:       r_addr[i] = 8'h12;
               default: r_addr[i] = AW'($urandom);
            endcase
            r_dat[i] = DW'($urandom);
            if (!r_we[i] && !ref_vld[r_addr[i]]) r_we[i] = 1'b1;
         end
         plan_and_drive(m);
         wait_round(1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
